// File: rtl/rtc_core_v5.sv
// rtc_core_v5: hh:mm:ss real-time clock core.
// A generic prescaler divides the board clock down to a one-second tick
// and a 24-hour time is kept internally. The display outputs offer a
// 12/24-hour format, loads are range-checked, and a daily alarm flag is
// sticky until it is cleared.
module rtc_core_v5 #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int PRESC_W       = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       mode_12h,
  input  logic       load,
  input  logic [2:0] addrs,
  input  logic [5:0] data_in,
  input  logic       alarm_en,
  input  logic       alarm_clr,
  output logic [5:0] seconds_out,
  output logic [5:0] minutes_out,
  output logic [4:0] hours_out,
  output logic       pm_out,
  output logic       tick_1hz,
  output logic       alarm_out
);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);

  logic [PRESC_W-1:0] presc;
  logic [5:0]         sec;
  logic [5:0]         min;
  logic [4:0]         hr;
  logic [5:0]         alarm_min;
  logic [4:0]         alarm_hr;
  logic               tick_r;
  logic               alarm_r;

  logic               tc;
  logic               ld_sec;
  logic               ld_min;
  logic               ld_hr;
  logic               ld_amin;
  logic               ld_ahr;
  logic               sec_carry;
  logic               min_carry;
  logic [5:0]         sec_n;
  logic [5:0]         min_n;
  logic [4:0]         hr_n;
  logic               alarm_hit;
  logic [4:0]         hr_mod12;

  assign tc = run && (presc == PRESC_MAX);

  // Decode the write strobe; out-of-range data and reserved addresses produce no write at all.
  always_comb begin
    ld_sec  = 1'b0;
    ld_min  = 1'b0;
    ld_hr   = 1'b0;
    ld_amin = 1'b0;
    ld_ahr  = 1'b0;
    if (load) begin
      case (addrs)
        3'd0:    ld_sec  = (data_in <= 6'd59);
        3'd1:    ld_min  = (data_in <= 6'd59);
        3'd2:    ld_hr   = (data_in <= 6'd23);
        3'd3:    ld_amin = (data_in <= 6'd59);
        3'd4:    ld_ahr  = (data_in <= 6'd23);
        default: ;
      endcase
    end
  end

  // Next time value: a loaded field overrides its tick update and, since it does not wrap, passes no carry upward.
  always_comb begin
    sec_carry = tc && (sec == 6'd59) && !ld_sec;
    min_carry = sec_carry && (min == 6'd59) && !ld_min;

    sec_n = sec;
    if (ld_sec)
      sec_n = data_in;
    else if (tc)
      sec_n = (sec == 6'd59) ? 6'd0 : sec + 6'd1;

    min_n = min;
    if (ld_min)
      min_n = data_in;
    else if (sec_carry)
      min_n = (min == 6'd59) ? 6'd0 : min + 6'd1;

    hr_n = hr;
    if (ld_hr)
      hr_n = data_in[4:0];
    else if (min_carry)
      hr_n = (hr == 5'd23) ? 5'd0 : hr + 5'd1;

    alarm_hit = tc && alarm_en && !(ld_sec || ld_min || ld_hr) &&
                (sec_n == 6'd0) && (min_n == alarm_min) && (hr_n == alarm_hr);
  end

  // Prescaler: counts only while running; a seconds write restarts the second.
  always_ff @(posedge clk) begin
    if (reset)
      presc <= '0;
    else if (ld_sec)
      presc <= '0;
    else if (run)
      presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
  end

  // Time and alarm registers take the precomputed next values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sec       <= 6'd0;
      min       <= 6'd0;
      hr        <= 5'd0;
      alarm_min <= 6'd0;
      alarm_hr  <= 5'd0;
    end else begin
      sec <= sec_n;
      min <= min_n;
      hr  <= hr_n;
      if (ld_amin)
        alarm_min <= data_in;
      if (ld_ahr)
        alarm_hr <= data_in[4:0];
    end
  end

  // Tick pulse lines up with the seconds update; the alarm flag is sticky and clearing beats setting.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_r  <= 1'b0;
      alarm_r <= 1'b0;
    end else begin
      tick_r <= tc;
      if (alarm_clr || !alarm_en)
        alarm_r <= 1'b0;
      else if (alarm_hit)
        alarm_r <= 1'b1;
    end
  end

  // Display formatting; midnight and noon both show as 12 in 12-hour mode.
  always_comb begin
    hr_mod12 = (hr >= 5'd12) ? hr - 5'd12 : hr;
    if (mode_12h)
      hours_out = (hr_mod12 == 5'd0) ? 5'd12 : hr_mod12;
    else
      hours_out = hr;
  end

  assign seconds_out = sec;
  assign minutes_out = min;
  assign pm_out      = (hr >= 5'd12);
  assign tick_1hz    = tick_r;
  assign alarm_out   = alarm_r;

endmodule

// File: tb/tb_rtc_core_v5.sv
// tb_rtc_core_v5: self-checking bench for rtc_core_v5 with TICKS_PER_SEC = 4.
// Expected output records are queued before each clock edge and compared
// one time unit after it.
module tb_rtc_core_v5;

  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       mode_12h;
  logic       load;
  logic [2:0] addrs;
  logic [5:0] data_in;
  logic       alarm_en;
  logic       alarm_clr;
  logic [5:0] seconds_out;
  logic [5:0] minutes_out;
  logic [4:0] hours_out;
  logic       pm_out;
  logic       tick_1hz;
  logic       alarm_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       tick;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
    logic       pm;
    logic       alarm;
  } exp_t;

  typedef struct {
    logic [2:0] addr;
    logic [5:0] data;
    logic       mode;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
    logic       pm;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[15];

  rtc_core_v5 #(.TICKS_PER_SEC(TPS), .PRESC_W(3)) dut (
    .clk(clk), .reset(reset), .run(run), .mode_12h(mode_12h), .load(load),
    .addrs(addrs), .data_in(data_in), .alarm_en(alarm_en), .alarm_clr(alarm_clr),
    .seconds_out(seconds_out), .minutes_out(minutes_out), .hours_out(hours_out),
    .pm_out(pm_out), .tick_1hz(tick_1hz), .alarm_out(alarm_out)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic exp_t mk(input logic t, input int s, input int m, input int h,
                              input logic p, input logic a);
    exp_t e;
    e.tick  = t;
    e.sec   = 6'(s);
    e.min   = 6'(m);
    e.hr    = 5'(h);
    e.pm    = p;
    e.alarm = a;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue the expectation for the coming edge, then advance past it.
  task automatic apply_stimulus(input exp_t e);
    sb.push_back(e);
    step();
  endtask

  // Pop the oldest expectation and compare every output against it.
  task automatic check_output(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_tick"},  {31'd0, tick_1hz},   {31'd0, e.tick});
    check({tag, "_sec"},   {26'd0, seconds_out}, {26'd0, e.sec});
    check({tag, "_min"},   {26'd0, minutes_out}, {26'd0, e.min});
    check({tag, "_hr"},    {27'd0, hours_out},   {27'd0, e.hr});
    check({tag, "_pm"},    {31'd0, pm_out},      {31'd0, e.pm});
    check({tag, "_alarm"}, {31'd0, alarm_out},   {31'd0, e.alarm});
  endtask

  task automatic expect_steps(input int n, input exp_t e, input string tag);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(e);
      check_output(tag);
    end
  endtask

  task automatic do_load(input logic [2:0] a, input logic [5:0] d);
    addrs   = a;
    data_in = d;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  function automatic vec_t mv(input int a, input int d, input logic md, input int s,
                              input int m, input int h, input logic p);
    vec_t v;
    v.addr = 3'(a);
    v.data = 6'(d);
    v.mode = md;
    v.sec  = 6'(s);
    v.min  = 6'(m);
    v.hr   = 5'(h);
    v.pm   = p;
    return v;
  endfunction

  initial begin
    // Register-write vectors starting from 13:00:00 with run stopped.
    vecs[0]  = mv(1, 63, 1,  0,  0,  1, 1);
    vecs[1]  = mv(0, 60, 1,  0,  0,  1, 1);
    vecs[2]  = mv(2, 24, 1,  0,  0,  1, 1);
    vecs[3]  = mv(2, 33, 1,  0,  0,  1, 1);
    vecs[4]  = mv(6,  5, 1,  0,  0,  1, 1);
    vecs[5]  = mv(7,  9, 0,  0,  0, 13, 1);
    vecs[6]  = mv(1, 45, 0,  0, 45, 13, 1);
    vecs[7]  = mv(0, 59, 0, 59, 45, 13, 1);
    vecs[8]  = mv(2,  0, 1, 59, 45, 12, 0);
    vecs[9]  = mv(2, 12, 1, 59, 45, 12, 1);
    vecs[10] = mv(2, 23, 0, 59, 45, 23, 1);
    vecs[11] = mv(2, 11, 1, 59, 45, 11, 0);
    vecs[12] = mv(2,  1, 1, 59, 45,  1, 0);
    vecs[13] = mv(1, 59, 0, 59, 59,  1, 0);
    vecs[14] = mv(1,  0, 0, 59,  0,  1, 0);

    reset = 1'b1; run = 1'b1; mode_12h = 1'b0; load = 1'b0;
    addrs = 3'd0; data_in = 6'd0; alarm_en = 1'b0; alarm_clr = 1'b0;

    // Reset state in both display modes.
    step();
    apply_stimulus(mk(0, 0, 0, 0, 0, 0));
    check_output("reset");
    mode_12h = 1'b1; #1;
    check("reset_hr12", {27'd0, hours_out}, 32'd12);
    mode_12h = 1'b0;
    reset = 1'b0;

    // Free run for 61 seconds: a tick every 4th edge, minute carry on the 60th.
    for (int k = 1; k <= TPS * 61; k++) begin
      apply_stimulus(mk((k % TPS) == 0, (k / TPS) % 60, (k / TPS) / 60, 0, 0, 0));
      check_output("count");
    end
    run = 1'b0;

    // Full-day rollover 23:59:59 -> 00:00:00.
    do_load(3'd2, 6'd23);
    do_load(3'd1, 6'd59);
    do_load(3'd0, 6'd59);
    run = 1'b1;
    expect_steps(TPS - 1, mk(0, 59, 59, 23, 1, 0), "pre_roll");
    expect_steps(1, mk(1, 0, 0, 0, 0, 0), "roll");
    run = 1'b0;
    mode_12h = 1'b1; #1;
    check("midnight_hr12", {27'd0, hours_out}, 32'd12);

    // 13h in 12h mode, then mode switch without a clock edge.
    do_load(3'd2, 6'd13);
    check("h13_12h", {27'd0, hours_out}, 32'd1);
    check("h13_pm", {31'd0, pm_out}, 32'd1);
    mode_12h = 1'b0; #1;
    check("h13_24h", {27'd0, hours_out}, 32'd13);

    // Table of writes: valid, out-of-range and reserved addresses.
    foreach (vecs[i]) begin
      addrs    = vecs[i].addr;
      data_in  = vecs[i].data;
      mode_12h = vecs[i].mode;
      load     = 1'b1;
      apply_stimulus(mk(0, vecs[i].sec, vecs[i].min, vecs[i].hr, vecs[i].pm, 0));
      load     = 1'b0;
      check_output($sformatf("vec%0d", i));
    end
    mode_12h = 1'b0;

    // Alarm at 07:30:00, sticky, then cleared by a pulse.
    do_load(3'd4, 6'd7);
    do_load(3'd3, 6'd30);
    do_load(3'd2, 6'd7);
    do_load(3'd1, 6'd29);
    do_load(3'd0, 6'd59);
    alarm_en = 1'b1;
    run = 1'b1;
    expect_steps(TPS - 1, mk(0, 59, 29, 7, 0, 0), "alm_pre");
    expect_steps(1, mk(1, 0, 30, 7, 0, 1), "alm_set");
    expect_steps(2, mk(0, 0, 30, 7, 0, 1), "alm_sticky");
    alarm_clr = 1'b1;
    apply_stimulus(mk(0, 0, 30, 7, 0, 0));
    alarm_clr = 1'b0;
    run = 1'b0;
    check_output("alm_clr");

    // Invalid alarm writes are ignored; clear held across the match edge wins.
    do_load(3'd3, 6'd60);
    do_load(3'd4, 6'd24);
    do_load(3'd1, 6'd29);
    do_load(3'd0, 6'd59);
    alarm_clr = 1'b1;
    run = 1'b1;
    expect_steps(TPS - 1, mk(0, 59, 29, 7, 0, 0), "clrheld_pre");
    expect_steps(1, mk(1, 0, 30, 7, 0, 0), "clrheld_edge");
    alarm_clr = 1'b0;
    expect_steps(1, mk(0, 0, 30, 7, 0, 0), "clrheld_after");
    run = 1'b0;

    // Alarm registers kept 07:30 despite the rejected writes.
    do_load(3'd1, 6'd29);
    do_load(3'd0, 6'd59);
    run = 1'b1;
    expect_steps(TPS - 1, mk(0, 59, 29, 7, 0, 0), "again_pre");
    expect_steps(1, mk(1, 0, 30, 7, 0, 1), "again_set");
    run = 1'b0;
    alarm_en = 1'b0;
    expect_steps(1, mk(0, 0, 30, 7, 0, 0), "en_off");

    // Loading a matching time directly does not raise the alarm.
    alarm_en = 1'b1;
    addrs = 3'd0; data_in = 6'd0; load = 1'b1;
    apply_stimulus(mk(0, 0, 30, 7, 0, 0));
    load = 1'b0;
    check_output("direct_match");

    // Stop mid-second, then resume with the remaining prescaler count.
    run = 1'b1;
    expect_steps(2, mk(0, 0, 30, 7, 0, 0), "run_a");
    run = 1'b0;
    expect_steps(10, mk(0, 0, 30, 7, 0, 0), "frozen");
    run = 1'b1;
    expect_steps(1, mk(0, 0, 30, 7, 0, 0), "resume");
    expect_steps(1, mk(1, 1, 30, 7, 0, 0), "resume_tick");

    // Seconds write one edge before the terminal count restarts the second.
    expect_steps(2, mk(0, 1, 30, 7, 0, 0), "pre_ld5");
    addrs = 3'd0; data_in = 6'd5; load = 1'b1;
    apply_stimulus(mk(0, 5, 30, 7, 0, 0));
    load = 1'b0;
    check_output("ld5");
    expect_steps(TPS - 1, mk(0, 5, 30, 7, 0, 0), "post_ld5");
    expect_steps(1, mk(1, 6, 30, 7, 0, 0), "ld5_tick");

    // Seconds write on the tick edge: no carry into minutes.
    do_load(3'd0, 6'd59);
    expect_steps(TPS - 1, mk(0, 59, 30, 7, 0, 0), "pre_tcsec");
    addrs = 3'd0; data_in = 6'd10; load = 1'b1;
    apply_stimulus(mk(1, 10, 30, 7, 0, 0));
    load = 1'b0;
    check_output("tc_ldsec");

    // Minutes write while seconds roll over: the write wins over the carry.
    do_load(3'd0, 6'd59);
    expect_steps(TPS - 1, mk(0, 59, 30, 7, 0, 0), "pre_tcmin");
    addrs = 3'd1; data_in = 6'd10; load = 1'b1;
    apply_stimulus(mk(1, 0, 10, 7, 0, 0));
    load = 1'b0;
    check_output("tc_ldmin");

    // Reset mid-operation beats a simultaneous write.
    do_load(3'd2, 6'd15);
    reset = 1'b1;
    addrs = 3'd2; data_in = 6'd5; load = 1'b1;
    apply_stimulus(mk(0, 0, 0, 0, 0, 0));
    check_output("mid_reset");
    mode_12h = 1'b1; #1;
    check("mid_reset_hr12", {27'd0, hours_out}, 32'd12);
    reset = 1'b0;
    load = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
